// File: rtl/adc_pkg.sv
// Shared types and defaults for the ADC lane packer: FSM state encoding,
// default geometry and the lane-index width helper.
package adc_pkg;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_FILL = 1'b1
   } state_t;

   localparam int DEF_SAMPLE_W = 14;
   localparam int DEF_LANES    = 4;
   localparam int DEF_LANE_W   = 16;

   // LANES is at least 2, so the index is always at least one bit wide.
   function automatic int lane_idx_w(input int lanes);
      return (lanes <= 2) ? 1 : $clog2(lanes);
   endfunction

endpackage

// File: rtl/adc_lane_outreg.sv
// Output holding register for the lane packer: decides load / consume / drop
// for each completed word and keeps the sticky, saturating overflow count.
module adc_lane_outreg
   import adc_pkg::*;
#(
   parameter int DATA_W    = DEF_LANES * DEF_LANE_W,
   parameter int OVF_CNT_W = 16
) (
   input  logic                 i_clk,
   input  logic                 i_nreset,
   input  logic                 i_load,
   input  logic [DATA_W-1:0]    i_word,
   input  logic                 i_ready,
   output logic [DATA_W-1:0]    o_data,
   output logic                 o_valid,
   output logic                 o_overflow,
   output logic [OVF_CNT_W-1:0] o_ovf_count
);

   // Handshake: a word transfers on any rising edge where o_valid && i_ready;
   // o_data holds steady while o_valid is high and i_ready is low, and a new
   // word may load on the same edge the held one is consumed.
   logic                 r_valid;
   logic [DATA_W-1:0]    r_data;
   logic                 r_overflow;
   logic [OVF_CNT_W-1:0] r_ovf_count;
   logic                 w_take;
   logic                 w_drop;

   assign w_take = i_load && (!r_valid || i_ready);
   assign w_drop = i_load && r_valid && !i_ready;

   always_ff @(posedge i_clk or negedge i_nreset) begin
      if (!i_nreset) begin
         r_valid     <= 1'b0;
         r_data      <= '0;
         r_overflow  <= 1'b0;
         r_ovf_count <= '0;
      end else begin
         if (w_take) begin
            r_valid <= 1'b1;
            r_data  <= i_word;
         end else if (r_valid && i_ready) begin
            r_valid <= 1'b0;
         end
         if (w_drop) begin
            r_overflow <= 1'b1;
            if (r_ovf_count != '1) begin
               r_ovf_count <= r_ovf_count + 1'b1;
            end
         end
      end
   end

   assign o_data      = r_data;
   assign o_valid     = r_valid;
   assign o_overflow  = r_overflow;
   assign o_ovf_count = r_ovf_count;

endmodule

// File: rtl/adc_lane_packer.sv
// Packs LANES consecutive ADC samples into one word with a valid/ready output.
// Optional internal ramp source enabled by ADC_LANE_PACKER_TESTPAT_EN.
module adc_lane_packer
   import adc_pkg::*;
#(
   parameter int SAMPLE_W  = DEF_SAMPLE_W,
   parameter int LANES     = DEF_LANES,
   parameter int LANE_W    = DEF_LANE_W,
   parameter int SIGN_EXT  = 0,
   parameter int OVF_CNT_W = 16
) (
   input  logic                    i_125clk,
   input  logic                    i_nreset,
   input  logic                    i_en,
   input  logic [SAMPLE_W-1:0]     i_sample,
   input  logic                    i_sample_valid,
   input  logic                    i_testpat,
   output logic [LANES*LANE_W-1:0] o_data,
   output logic                    o_valid,
   input  logic                    i_ready,
   output logic                    o_overflow,
   output logic [OVF_CNT_W-1:0]    o_ovf_count,
   output logic                    o_busy
);

   localparam int DATA_W = LANES * LANE_W;
   localparam int IW     = lane_idx_w(LANES);
   localparam logic [IW-1:0] LAST_IDX = IW'(LANES - 1);

   state_t               r_state;
   state_t               w_state_nxt;
   logic [IW-1:0]        r_idx;
   logic [DATA_W-1:0]    r_asm;
   logic [DATA_W-1:0]    w_word;
   logic [LANE_W-1:0]    w_lane;
   logic [SAMPLE_W-1:0]  w_src;
   logic                 w_src_valid;
   logic                 w_accept;
   logic                 w_complete;

`ifdef ADC_LANE_PACKER_TESTPAT_EN
   logic [SAMPLE_W-1:0]  r_ramp;

   assign w_src       = i_testpat ? r_ramp : i_sample;
   assign w_src_valid = i_testpat ? 1'b1 : i_sample_valid;

   // Ramp steps once per completed word, so every lane of a word matches.
   always_ff @(posedge i_125clk or negedge i_nreset) begin
      if (!i_nreset) begin
         r_ramp <= '0;
      end else if (w_complete && i_testpat) begin
         r_ramp <= r_ramp + 1'b1;
      end
   end
`else
   logic w_unused_testpat;

   assign w_unused_testpat = i_testpat;
   assign w_src            = i_sample;
   assign w_src_valid      = i_sample_valid;
`endif

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_IDLE: if (i_en)  w_state_nxt = ST_FILL;
         ST_FILL: if (!i_en) w_state_nxt = ST_IDLE;
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   assign w_accept   = (r_state == ST_FILL) && i_en && w_src_valid;
   assign w_complete = w_accept && (r_idx == LAST_IDX);

   always_comb begin
      w_lane = '0;
      w_lane[SAMPLE_W-1:0] = w_src;
      if (SIGN_EXT != 0) begin
         for (int b = SAMPLE_W; b < LANE_W; b++) begin
            w_lane[b] = w_src[SAMPLE_W-1];
         end
      end
   end

   // The word handed to the output register already contains the last lane.
   always_comb begin
      w_word = r_asm;
      for (int k = 0; k < LANES; k++) begin
         if (r_idx == IW'(k)) begin
            w_word[k*LANE_W +: LANE_W] = w_lane;
         end
      end
   end

   always_ff @(posedge i_125clk or negedge i_nreset) begin
      if (!i_nreset) begin
         r_state <= ST_IDLE;
         r_idx   <= '0;
         r_asm   <= '0;
      end else begin
         r_state <= w_state_nxt;
         if (r_state == ST_IDLE || !i_en) begin
            r_idx <= '0;
         end else if (w_accept) begin
            r_idx <= w_complete ? '0 : r_idx + 1'b1;
         end
         if (w_accept) begin
            r_asm <= w_word;
         end
      end
   end

   assign o_busy = (r_state == ST_FILL) && (r_idx != '0);

   adc_lane_outreg #(
      .DATA_W    (DATA_W),
      .OVF_CNT_W (OVF_CNT_W)
   ) u_outreg (
      .i_clk       (i_125clk),
      .i_nreset    (i_nreset),
      .i_load      (w_complete),
      .i_word      (w_word),
      .i_ready     (i_ready),
      .o_data      (o_data),
      .o_valid     (o_valid),
      .o_overflow  (o_overflow),
      .o_ovf_count (o_ovf_count)
   );

endmodule

// File: tb/tb_adc_lane_packer.sv
// Directed bench for adc_lane_packer: vector table for the basic packing,
// restart and gap cases, plus hand sequences for sign extension, overflow and reset.
module tb_adc_lane_packer;

   logic        clk;
   logic        nreset;
   logic        en;
   logic [13:0] sample;
   logic        sample_valid;
   logic        testpat;
   logic        ready;

   logic [63:0] data,     data_sx;
   logic        valid,    valid_sx;
   logic        ovf,      ovf_sx;
   logic [15:0] ovf_cnt;
   logic [1:0]  ovf_cnt_sx;
   logic        busy,     busy_sx;

   int checks = 0;
   int errors = 0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   adc_lane_packer u_dut (
      .i_125clk       (clk),
      .i_nreset       (nreset),
      .i_en           (en),
      .i_sample       (sample),
      .i_sample_valid (sample_valid),
      .i_testpat      (testpat),
      .o_data         (data),
      .o_valid        (valid),
      .i_ready        (ready),
      .o_overflow     (ovf),
      .o_ovf_count    (ovf_cnt),
      .o_busy         (busy)
   );

   adc_lane_packer #(.SIGN_EXT(1), .OVF_CNT_W(2)) u_dut_sx (
      .i_125clk       (clk),
      .i_nreset       (nreset),
      .i_en           (en),
      .i_sample       (sample),
      .i_sample_valid (sample_valid),
      .i_testpat      (testpat),
      .o_data         (data_sx),
      .o_valid        (valid_sx),
      .i_ready        (ready),
      .o_overflow     (ovf_sx),
      .o_ovf_count    (ovf_cnt_sx),
      .o_busy         (busy_sx)
   );

   typedef struct {
      logic        en;
      logic        sv;
      logic [13:0] smp;
      logic        rdy;
      logic        exp_valid;
      logic        exp_busy;
      logic [63:0] exp_data;
      logic        chk_data;
   } vec_t;

   vec_t vecs[$];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s act=%h exp=%h", name, act, exp);
      end
   endtask

   task automatic add(input logic e, input logic v, input logic [13:0] s, input logic r,
                      input logic ev, input logic eb, input logic [63:0] ed, input logic cd);
      vec_t t;
      t.en = e; t.sv = v; t.smp = s; t.rdy = r;
      t.exp_valid = ev; t.exp_busy = eb; t.exp_data = ed; t.chk_data = cd;
      vecs.push_back(t);
   endtask

   task automatic drive(input logic e, input logic v, input logic [13:0] s, input logic r);
      en = e; sample_valid = v; sample = s; ready = r;
      @(posedge clk);
      #1;
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, "_data"},    data,             64'h0);
      chk({tag, "_valid"},   {63'h0, valid},   64'h0);
      chk({tag, "_ovf"},     {63'h0, ovf},     64'h0);
      chk({tag, "_ovf_cnt"}, {48'h0, ovf_cnt}, 64'h0);
      chk({tag, "_busy"},    {63'h0, busy},    64'h0);
      chk({tag, "_sx_cnt"},  {62'h0, ovf_cnt_sx}, 64'h0);
   endtask

   initial begin
      nreset = 1'b0; en = 1'b0; sample = '0; sample_valid = 1'b0;
      testpat = 1'b0; ready = 1'b0;

      // ---- vector table: plain pack, restart after abort, valid gaps ----
      add(1, 0, 14'h0000, 1, 0, 0, 64'h0, 0);
      add(1, 1, 14'h0001, 1, 0, 1, 64'h0, 0);
      add(1, 1, 14'h0002, 1, 0, 1, 64'h0, 0);
      add(1, 1, 14'h0003, 1, 0, 1, 64'h0, 0);
      add(1, 1, 14'h0004, 1, 1, 0, 64'h0004_0003_0002_0001, 1);
      add(1, 0, 14'h1234, 1, 0, 0, 64'h0, 0);
      add(1, 1, 14'h0011, 1, 0, 1, 64'h0, 0);
      add(1, 1, 14'h0012, 1, 0, 1, 64'h0, 0);
      add(0, 1, 14'h0099, 1, 0, 0, 64'h0, 0);
      add(1, 0, 14'h0000, 1, 0, 0, 64'h0, 0);
      add(1, 1, 14'h000A, 1, 0, 1, 64'h0, 0);
      add(1, 1, 14'h000B, 1, 0, 1, 64'h0, 0);
      add(1, 1, 14'h000C, 1, 0, 1, 64'h0, 0);
      add(1, 1, 14'h000D, 1, 1, 0, 64'h000D_000C_000B_000A, 1);
      add(1, 0, 14'h0000, 1, 0, 0, 64'h0, 0);
      add(1, 1, 14'h0005, 1, 0, 1, 64'h0, 0);
      add(1, 0, 14'h1234, 1, 0, 1, 64'h0, 0);
      add(1, 0, 14'h2345, 1, 0, 1, 64'h0, 0);
      add(1, 1, 14'h0006, 1, 0, 1, 64'h0, 0);
      add(1, 1, 14'h0007, 1, 0, 1, 64'h0, 0);
      add(1, 0, 14'h3456, 1, 0, 1, 64'h0, 0);
      add(1, 1, 14'h0008, 1, 1, 0, 64'h0008_0007_0006_0005, 1);
      add(1, 0, 14'h0000, 1, 0, 0, 64'h0, 0);

      // ---- reset state ----
      #2;
      chk_reset_outputs("reset");
      repeat (3) @(posedge clk);
      @(negedge clk);
      nreset = 1'b1;
      drive(0, 0, 14'h0, 1);
      chk("no_word_on_release", {63'h0, valid}, 64'h0);

      for (int i = 0; i < vecs.size(); i++) begin
         drive(vecs[i].en, vecs[i].sv, vecs[i].smp, vecs[i].rdy);
         chk($sformatf("vec%0d_valid", i), {63'h0, valid}, {63'h0, vecs[i].exp_valid});
         chk($sformatf("vec%0d_busy", i),  {63'h0, busy},  {63'h0, vecs[i].exp_busy});
         if (vecs[i].chk_data) chk($sformatf("vec%0d_data", i), data, vecs[i].exp_data);
      end
      chk("abort_ovf_cnt", {48'h0, ovf_cnt}, 64'h0);
      chk("abort_ovf",     {63'h0, ovf},     64'h0);

      // ---- zero-pad vs sign-extension ----
      drive(1, 1, 14'h2000, 1);
      drive(1, 1, 14'h1FFF, 1);
      drive(1, 1, 14'h3FFF, 1);
      drive(1, 1, 14'h0000, 1);
      chk("zpad_data", data,    64'h0000_3FFF_1FFF_2000);
      chk("sext_data", data_sx, 64'h0000_FFFF_1FFF_E000);
      drive(1, 0, 14'h0, 1);
      chk("sext_clear", {63'h0, valid}, 64'h0);

      // ---- back-pressure: word 1 held, words 2..5 dropped, word 6 swaps in ----
      for (int w = 1; w <= 6; w++) begin
         for (int l = 0; l < 4; l++) begin
            drive(1, 1, 14'(w * 256 + l + 1), (w == 6 && l == 3));
            if (w == 6 && l == 2) begin
               chk("bp_hold_valid", {63'h0, valid}, 64'h1);
               chk("bp_hold_data",  data, 64'h0104_0103_0102_0101);
            end
         end
         if (w == 1) begin
            chk("bp_w1_data", data, 64'h0104_0103_0102_0101);
            chk("bp_w1_ovf",  {63'h0, ovf}, 64'h0);
         end else if (w <= 5) begin
            chk($sformatf("bp_w%0d_data", w), data, 64'h0104_0103_0102_0101);
            chk($sformatf("bp_w%0d_cnt", w), {48'h0, ovf_cnt}, 64'(w - 1));
            chk($sformatf("bp_w%0d_ovf", w), {63'h0, ovf}, 64'h1);
         end
      end
      chk("bp_sat_cnt",    {62'h0, ovf_cnt_sx}, 64'h3);
      chk("bp_swap_valid", {63'h0, valid}, 64'h1);
      chk("bp_swap_data",  data, 64'h0604_0603_0602_0601);
      chk("bp_swap_cnt",   {48'h0, ovf_cnt}, 64'h4);
      drive(1, 0, 14'h0, 1);
      chk("bp_drain", {63'h0, valid}, 64'h0);
      chk("bp_sticky", {63'h0, ovf}, 64'h1);

`ifdef ADC_LANE_PACKER_TESTPAT_EN
      // ---- internal ramp: lanes of word n all equal n ----
      testpat = 1'b1;
      for (int c = 1; c <= 12; c++) begin
         drive(1, 0, 14'h1555, 1);
         chk($sformatf("ramp_c%0d_valid", c), {63'h0, valid}, {63'h0, (c % 4 == 0)});
         if (c % 4 == 0) chk($sformatf("ramp_c%0d_data", c), data, 64'(c / 4 - 1) * 64'h0001_0001_0001_0001);
      end
      drive(1, 0, 14'h0, 1);
      drive(1, 0, 14'h0, 1);
`else
      // ---- i_testpat has no effect in this build ----
      testpat = 1'b1;
      for (int c = 1; c <= 6; c++) begin
         drive(1, 0, 14'h1555, 1);
         chk($sformatf("notp_c%0d_valid", c), {63'h0, valid}, 64'h0);
      end
      drive(1, 1, 14'h0021, 1);
      drive(1, 1, 14'h0022, 1);
`endif
      chk("midword_busy", {63'h0, busy}, 64'h1);

      // ---- asynchronous reset mid-word ----
      #2;
      nreset = 1'b0;
      #1;
      chk_reset_outputs("async_rst");
      @(negedge clk);
      nreset = 1'b1;
      testpat = 1'b0;
      drive(0, 0, 14'h0, 1);
      drive(0, 0, 14'h0, 1);
      chk("post_rst_valid", {63'h0, valid}, 64'h0);
      chk("post_rst_busy",  {63'h0, busy},  64'h0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/adc_lane_packer.md
Name: adc_lane_packer

Overview:
- Parametrised successor to the fixed four-sample ADC packer.
- Collects LANES consecutive SAMPLE_W-bit ADC samples into one LANES*LANE_W-bit word and presents it on a valid/ready output toward the clock-crossing RAM writer.
- Adds over the old block: input-valid qualification, an output handshake, overflow accounting, a sign-extension mode and an enable-controlled restart.
- Sits in the 125 MHz ADC domain, between the ADC capture pins and the CDC buffer.

Parameters:
- SAMPLE_W, 14: ADC sample width in bits.
- LANES, 4: samples packed per output word; must be >= 2.
- LANE_W, 16: bit pitch of each lane; must be >= SAMPLE_W.
- SIGN_EXT, 0: 0 = zero-pad lane bits above SAMPLE_W; 1 = replicate the sample MSB into them.
- OVF_CNT_W, 16: width of the dropped-word counter.

Ports:
- i_125clk  input  1  sample clock; all logic is on its rising edge.
- i_nreset  input  1  asynchronous, active-low reset.
- i_en  input  1  packer enable; low discards any partial word and holds in IDLE.
- i_sample  input  SAMPLE_W  ADC sample.
- i_sample_valid  input  1  i_sample is valid this cycle.
- i_testpat  input  1  selects the internal ramp source; present in both builds, ignored without the macro.
- o_data  output  LANES*LANE_W  packed word; lane k occupies bits [k*LANE_W +: LANE_W].
- o_valid  output  1  o_data holds an unconsumed word.
- i_ready  input  1  consumer accepts o_data when o_valid && i_ready.
- o_overflow  output  1  sticky flag: at least one word has been dropped.
- o_ovf_count  output  OVF_CNT_W  dropped-word count; saturates at all-ones.
- o_busy  output  1  FILL state and lane index != 0 (partial word pending).

Behaviour:
- Reset: asynchronous while i_nreset is low. Effects:
  - state = IDLE, lane index = 0, assembly register = 0;
  - o_data = 0, o_valid = 0, o_overflow = 0, o_ovf_count = 0, o_busy = 0, ramp = 0.
  - Reset mid-word discards everything. No word is emitted on reset release.
- States:
  - IDLE: when i_en = 1, move to FILL next cycle with lane index 0.
  - FILL: each accepted sample writes lane[index] and increments index.
    - At index = LANES-1, the write completes the word and index wraps to 0.
    - When i_en = 0, return to IDLE next cycle. The partial word is dropped and not counted as overflow. o_valid and o_data are untouched.
- Sample accept: in FILL, when i_sample_valid = 1. Cycles with valid low leave index and lanes unchanged (gaps allowed).
- Lane content:
  - Lane bits [SAMPLE_W-1:0] = sample.
  - Upper LANE_W-SAMPLE_W bits = 0, or the sample MSB when SIGN_EXT = 1.
  - Lanes are fully rewritten each word; no stale bits carry over.
- Latency: the completed word appears on o_data with o_valid = 1 on the cycle after the last lane's sample is accepted.
- Output holding:
  - o_data is stable while o_valid = 1 and i_ready = 0.
  - o_valid clears the cycle after a handshake unless a new word loads in the same edge.
- Simultaneous events, on the cycle a new word completes:
  - o_valid = 0: load the word; o_valid goes to 1.
  - o_valid = 1 and i_ready = 1: the old word is consumed and the new word loads; o_valid stays 1 with no bubble.
  - o_valid = 1 and i_ready = 0: the new word is dropped and the held word is kept. o_overflow is set and o_ovf_count increments, saturating.
- o_overflow and o_ovf_count clear only on reset.
- Full throughput: one word per LANES cycles with i_sample_valid held high and i_ready high.

Optional Feature:
- Macro: ADC_LANE_PACKER_TESTPAT_EN.
- Defined: when i_testpat = 1, the sample source is an internal SAMPLE_W-bit ramp.
  - The ramp is taken as valid every FILL cycle; i_sample_valid is ignored.
  - The ramp increments on each word completion, wrapping at 2^SAMPLE_W - 1 to 0, so all lanes of a word carry the same value. This matches the legacy fake-ADC pattern.
  - The ramp keeps its value across IDLE and resets only on i_nreset.
  - Switching i_testpat takes effect on the next sample; there is no restart.
- Undefined: no ramp logic is built, i_testpat is ignored, and the source is always i_sample.

Decomposition:
- Shared package adc_pkg holds:
  - state encoding (IDLE, FILL) as a 1-bit enum;
  - defaults for SAMPLE_W / LANES / LANE_W;
  - a function giving the lane-index width, ceil(log2(LANES)).
- One natural sub-module, adc_lane_outreg: the output holding register with the load/consume/drop decision and the saturating overflow counter.
- The packer core owns the FSM, lane index, lane assembly and ramp.

Test Plan:
1. Defaults, i_en = 1, samples 0x0001..0x0004 back-to-back with valid, i_ready = 1 → o_data = 0x0004_0003_0002_0001, o_valid high for 1 cycle, appearing 1 cycle after the 4th sample.
2. SIGN_EXT = 1, samples 0x2000, 0x1FFF, 0x3FFF, 0x0000 → o_data = 0x0000_FFFF_1FFF_E000.
3. i_ready = 0 held across 3 completed words → o_data keeps word 1; o_ovf_count = 2, o_overflow = 1. Then complete a word on the same cycle i_ready = 1 → next o_data = new word, o_valid stays 1.
4. Two samples accepted, then i_en = 0 for 1 cycle, then i_en = 1 and 4 samples 0xA..0xD → o_data = 0x000D_000C_000B_000A; o_ovf_count unchanged.
5. i_sample_valid toggling 1-0-0-1-1-0-1 with samples 5,6,7,8 on the valid cycles → exactly one word, 0x0008_0007_0006_0005.
6. Macro defined, i_testpat = 1, i_ready = 1 for 12 cycles → words with all lanes = 0, then 1, then 2. Assert i_nreset low mid-word → all outputs 0 immediately.
